// File: rtl/utm_pkg.sv
// Shared constants for the UTM direction lookup: state indices, symbol codes,
// direction encodings and the per-state direction masks.
package utm_pkg;

    localparam int ST_A = 0;
    localparam int ST_B = 1;
    localparam int ST_C = 2;
    localparam int ST_D = 3;
    localparam int ST_E = 4;
    localparam int ST_F = 5;
    localparam int ST_G = 6;
    localparam int ST_H = 7;

    localparam logic [2:0] SYM_0 = 3'b000;
    localparam logic [2:0] SYM_1 = 3'b001;
    localparam logic [2:0] SYM_2 = 3'b010;
    localparam logic [2:0] SYM_3 = 3'b011;
    localparam logic [2:0] SYM_4 = 3'b100;
    localparam logic [2:0] SYM_5 = 3'b101;
    localparam logic [2:0] SYM_6 = 3'b110;
    localparam logic [2:0] SYM_7 = 3'b111;
    localparam logic [2:0] SYM_UNUSED = SYM_3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bit k of each mask is the move direction for symbol code k.
    localparam logic [7:0] MASK_A = 8'hA6;
    localparam logic [7:0] MASK_B = 8'h51;
    localparam logic [7:0] MASK_C = 8'hF0;
    localparam logic [7:0] MASK_D = 8'h07;
    localparam logic [7:0] MASK_E = 8'h95;
    localparam logic [7:0] MASK_F = 8'h62;
    localparam logic [7:0] MASK_G = 8'hC4;
    localparam logic [7:0] MASK_H = 8'h33;

    localparam logic [7:0][7:0] DIR_MASKS = {
        MASK_H, MASK_G, MASK_F, MASK_E,
        MASK_D, MASK_C, MASK_B, MASK_A
    };

endpackage

// File: rtl/utm_direction_lut.sv
// Combinational state/symbol -> direction lookup (AND-OR of per-state masks).
// Illegal-input flag present only with UTM_DIRECTION_STATE_CHECK_EN.
module utm_direction_lut
    import utm_pkg::*;
#(
    parameter int NUM_STATES = 8
) (
    input  logic [NUM_STATES-1:0] state,
    input  logic [2:0]            sym,
    output logic                  dir
`ifdef UTM_DIRECTION_STATE_CHECK_EN
    ,
    output logic                  illegal
`endif
);

    logic [NUM_STATES-1:0] hit;

    // Every set state bit contributes its mask bit; no priority between states.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            hit[i] = state[i] & DIR_MASKS[i][sym];
        end
    end

    assign dir = |hit;

`ifdef UTM_DIRECTION_STATE_CHECK_EN
    logic st_zero;
    logic st_multi;

    assign st_zero  = ~|state;
    assign st_multi = |(state & (state - NUM_STATES'(1)));
    assign illegal  = st_zero | st_multi | (sym == SYM_UNUSED);
`endif

endmodule

// File: rtl/utm_direction.sv
// Registered head-move direction for the UTM datapath (1 = right, 0 = left).
// Optional registered illegal-state flag: define UTM_DIRECTION_STATE_CHECK_EN.
module utm_direction
    import utm_pkg::*;
#(
    parameter int   NUM_STATES = 8,
    parameter logic DIR_RESET  = DIR_LEFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STATES-1:0] state,
    input  logic                  s2,
    input  logic                  s1,
    input  logic                  s0,
    output logic                  direction
`ifdef UTM_DIRECTION_STATE_CHECK_EN
    ,
    output logic                  state_err
`endif
);

    logic [2:0] sym;
    logic       dir_nxt;

    assign sym = {s2, s1, s0};

`ifdef UTM_DIRECTION_STATE_CHECK_EN
    logic err_nxt;

    utm_direction_lut #(
        .NUM_STATES(NUM_STATES)
    ) u_lut (
        .state  (state),
        .sym    (sym),
        .dir    (dir_nxt),
        .illegal(err_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_err <= 1'b0;
        end else begin
            state_err <= err_nxt;
        end
    end
`else
    utm_direction_lut #(
        .NUM_STATES(NUM_STATES)
    ) u_lut (
        .state(state),
        .sym  (sym),
        .dir  (dir_nxt)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            direction <= DIR_RESET;
        end else begin
            direction <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_utm_direction.sv
// Directed self-checking bench for utm_direction.
// Covers reset, full mask sweep, latency, illegal inputs and async reset.
module tb_utm_direction;

    logic       clk;
    logic       rst_n;
    logic [7:0] state;
    logic [2:0] sym;
    logic       direction;
`ifdef UTM_DIRECTION_STATE_CHECK_EN
    logic       state_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Independent copy of the direction table, bit k = symbol code k.
    logic [7:0] tbl [8];
    logic [2:0] legal [7];

    utm_direction dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .s2       (sym[2]),
        .s1       (sym[1]),
        .s0       (sym[0]),
        .direction(direction)
`ifdef UTM_DIRECTION_STATE_CHECK_EN
        ,
        .state_err(state_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = 8'hA6; tbl[1] = 8'h51; tbl[2] = 8'hF0; tbl[3] = 8'h07;
        tbl[4] = 8'h95; tbl[5] = 8'h62; tbl[6] = 8'hC4; tbl[7] = 8'h33;
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b101; legal[5] = 3'b110;
        legal[6] = 3'b111;

        rst_n = 1'b0;
        state = 8'h01;
        sym   = 3'b000;

        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("reset_dir_%0d", k), direction, 1'b0);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
            chk($sformatf("reset_err_%0d", k), state_err, 1'b0);
`endif
        end

        // Release between edges, then first lookup: M_A[0] = 0, M_A[1] = 1.
        #2 rst_n = 1'b1;
        step();
        chk("release_A_000", direction, 1'b0);
        sym = 3'b001;
        step();
        chk("A_001", direction, 1'b1);

        // Full sweep of legal symbols over every one-hot state.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7; j++) begin
                state = 8'(1) << i;
                sym   = legal[j];
                step();
                chk($sformatf("sweep_s%0d_y%0d", i, sym), direction,
                    tbl[i][sym]);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
                chk($sformatf("sweep_err_s%0d_y%0d", i, sym), state_err,
                    1'b0);
`endif
            end
        end

        // Hand-picked spot checks.
        state = 8'h04; sym = 3'b100; step();
        chk("C_100", direction, 1'b1);
        state = 8'h08; sym = 3'b101; step();
        chk("D_101", direction, 1'b0);
        state = 8'h80; sym = 3'b000; step();
        chk("H_000", direction, 1'b1);

        // Latency: C -> D with sym 000 only takes effect at the next edge.
        state = 8'h04; sym = 3'b000; step();
        chk("lat_C_000", direction, 1'b0);
        state = 8'h08;
        #3;
        chk("lat_hold", direction, 1'b0);
        step();
        chk("lat_D_000", direction, 1'b1);

        // Unused symbol always gives left.
        for (int i = 0; i < 8; i++) begin
            state = 8'(1) << i;
            sym   = 3'b011;
            step();
            chk($sformatf("unused_s%0d", i), direction, 1'b0);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
            chk($sformatf("unused_err_s%0d", i), state_err, 1'b1);
`endif
        end

        state = 8'h00; sym = 3'b000; step();
        chk("zero_state", direction, 1'b0);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
        chk("zero_state_err", state_err, 1'b1);
`endif

        state = 8'h03; sym = 3'b000; step();
        chk("multi_AB_000", direction, 1'b1);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
        chk("multi_AB_err", state_err, 1'b1);
`endif

        // A|C, sym 001: M_A[1]=1, M_C[1]=0 -> 1; sym 110: 0|1 -> 1.
        state = 8'h05; sym = 3'b001; step();
        chk("multi_AC_001", direction, 1'b1);
        sym = 3'b110; step();
        chk("multi_AC_110", direction, 1'b1);
        // A|D sym 100: 0|0 -> 0.
        state = 8'h09; sym = 3'b100; step();
        chk("multi_AD_100", direction, 1'b0);

        // Back to a legal vector so the error flag clears.
        state = 8'h08; sym = 3'b000; step();
        chk("pre_async_dir", direction, 1'b1);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
        chk("pre_async_err", state_err, 1'b0);
        state = 8'h00; step();
        chk("pre_async_err1", state_err, 1'b1);
        state = 8'h08;
        step();
        state = 8'h00;
        chk("pre_async_dir2", direction, 1'b1);
`endif

        // Async reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_dir", direction, 1'b0);
`ifdef UTM_DIRECTION_STATE_CHECK_EN
        chk("async_err", state_err, 1'b0);
`endif
        step();
        chk("async_hold", direction, 1'b0);

        state = 8'h80; sym = 3'b000;
        #2 rst_n = 1'b1;
        step();
        chk("post_async_H_000", direction, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/utm_direction.md
Name: utm_direction

Overview:
- Direction lookup for the universal Turing machine datapath.
- Maps the current one-hot machine state (A..H) and the 3-bit tape symbol under the head to the head-move direction: 1 = right, 0 = left.
- Sits between the state register / tape read path and the head-position counter.
- Output is registered; the counter consumes it one cycle after the inputs are presented.

Parameters:
- NUM_STATES, 8, number of one-hot machine states. Fixed at 8; other values are not supported.
- DIR_RESET, 1'b0, reset value of direction (0 = left).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk at the integration level.
- state  input  8  one-hot current state; bit i = state A+i (bit0=A ... bit7=H).
- s2  input  1  symbol bit 2 (MSB).
- s1  input  1  symbol bit 1.
- s0  input  1  symbol bit 0 (LSB).
- direction  output  1  registered move direction: 1 = right, 0 = left.
- state_err  output  1  only when STATE_CHECK_EN is defined; registered illegal-state flag.

Behaviour:
- Reset: while rst_n = 0, direction = DIR_RESET (0) and state_err = 0, independent of clk.
- Symbol code sym = {s2,s1,s0}. Legal codes: 000, 001, 010, 100, 101, 110, 111. Code 011 is unused.
- Lookup: per-state 8-bit mask M; bit k of M is the direction for symbol code k. Bit 3 of every mask is 0.
- Mask values:
  - A = 0xA6
  - B = 0x51
  - C = 0xF0
  - D = 0x07
  - E = 0x95
  - F = 0x62
  - G = 0xC4
  - H = 0x33
- Next direction = OR over i of (state[i] AND M_i[sym]). Implement as AND-OR logic, not a priority mux.
- Consequences of the AND-OR form:
  - state = 0x00 gives 0.
  - A multi-hot state gives the OR of the selected masks.
  - sym = 011 always gives 0.
- Latency: exactly 1 clock.
  - direction updates on every rising clk edge; there is no enable.
  - Inputs presented before edge N appear on direction after edge N.
- Inputs are not registered internally; they must meet setup/hold to clk.
- Reset mid-operation: the output returns to 0 immediately. The first valid lookup appears on the first rising edge after rst_n deasserts.

Optional Feature:
- Macro: UTM_DIRECTION_STATE_CHECK_EN.
- Defined:
  - state_err port exists.
  - state_err registers 1 when state is not exactly one-hot (zero or ≥2 bits set) OR sym = 011; otherwise it registers 0.
  - Same 1-cycle latency as direction; reset value 0.
  - direction behaviour is unchanged.
- Undefined: state_err port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package utm_pkg holds:
  - state index constants ST_A..ST_H (0..7);
  - symbol code constants SYM_0..SYM_7, with SYM_UNUSED = 3'b011;
  - DIR_LEFT = 0 and DIR_RIGHT = 1;
  - the eight 8-bit direction mask constants listed above.
- One sub-module is natural: utm_direction_lut, a purely combinational state/symbol → direction (and illegal flag) function. The top adds only the async-reset output register(s).

Test Plan:
- Reset: hold rst_n = 0 with state = 0x01 and sym = 000, toggling clk → direction = 0 throughout. Release reset → direction = M_A[0] = 0 after the first edge.
- Full sweep: for each state 1<<i, i = 0..7, apply sym in order 000, 001, 010, 100, 101, 110, 111, one clk per vector. Check direction one edge later against the mask table. Examples:
  - A, sym 001 → 1.
  - C, sym 100 → 1.
  - D, sym 101 → 0.
  - H, sym 000 → 1.
- Latency: change state from 0x04 (C) to 0x08 (D) with sym = 000. direction stays 0 (M_C[0]) until the next edge, then becomes 1 (M_D[0]).
- Unused symbol and illegal states:
  - sym = 011 on any state → direction = 0.
  - state = 0x00 → 0.
  - state = 0x03 (A|B) with sym 000 → 1 (OR: M_B[0]=1).
  - With UTM_DIRECTION_STATE_CHECK_EN defined, state_err = 1 for each of these cases and 0 for legal ones.
- Async reset mid-run: assert rst_n low between clock edges while direction = 1 → direction falls to 0 without waiting for a clk edge.
